pipelined_control_unit: RTL and testbench
=========================================

# pipelined_control_unit

Registered RV32IM decode stage with multi-cycle M-extension sequencing. It decodes one instruction per cycle into the ID/EX control bundle and registers the result, with stall and flush. It holds multiply and divide operations in EX for a parametrised number of cycles while back-pressuring fetch. It flags illegal encodings, and it can be built with the M extension disabled.

## Interface
- ENABLE_M, 1: 1 = decode RV32M ops; 0 = treat RV32M ops as illegal.
- MUL_LATENCY, 1: EX cycles for MUL/MULH/MULHSU/MULHU (funct3[2]=0). Legal range 1..255.
- DIV_LATENCY, 8: EX cycles for DIV/DIVU/REM/REMU (funct3[2]=1). Legal range 1..255.
- CLK input 1: single clock; all state updates on the rising edge.
- RESET input 1: synchronous, active-high.
- Instruction input 32: instruction word from IF/ID.
- instr_valid input 1: Instruction is valid this cycle.
- stall_in input 1: downstream stall; hold the output register.
- flush input 1: kill the output slot and any multi-cycle op.
- stall_out output 1: upstream must hold Instruction. Equals (state==MBUSY) | stall_in.
- ctrl_valid output 1: the registered bundle is a real instruction.
- ALU_sel output 5 / reg_write_EN output 1 / mem_write output 3 / mem_read output 4 / branch_sel output 4 / immeadiate_sel output 3 / operand1_sel output 1 / operand2_sel output 1 / reg_write_sel output 2: registered control bundle.
- illegal_op output 1: registered; the slot held an illegal encoding.
- mc_last output 1: combinational; ctrl_valid & out_is_m & (state==IDLE), i.e. the final EX cycle of an M op.

## Operation
- Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
- Any other opcode is illegal. OP with funct7=0000001 is illegal when ENABLE_M=0.
- Decode fields:
  - reg_write_EN: 1 except BRANCH and STORE.
  - immeadiate_sel: LUI/AUIPC 000; JAL 001; JALR/LOAD/OP-IMM 010; BRANCH 011; STORE 100; OP 000.
  - operand1_sel: 1 for AUIPC, JAL, BRANCH.
  - operand2_sel: 1 for every legal opcode except OP.
  - ALU_sel[2:0]: 000 for LUI/AUIPC/JAL/BRANCH/LOAD/STORE; 001 for JALR; funct3 otherwise.
  - ALU_sel[3]: LUI, or OP with funct7=0000001.
  - ALU_sel[4]: LUI; JALR; OP funct3=000 funct7=0100000 (SUB); OP funct3=101 funct7=0100000 (SRA); OP-IMM funct3=101 funct7=0100000 (SRAI).
  - branch_sel: {JAL|JALR|BRANCH, (JAL|JALR) ? 010 : funct3}.
  - mem_write: {STORE, funct3[1:0]}.
  - mem_read: {LOAD, funct3}.
  - reg_write_sel: 00 for JAL/JALR; 01 for LOAD; 10 otherwise.
- Bubble: every bundle field 0 and ctrl_valid=0.
- Illegal slot: bubble fields with illegal_op=1.
- FSM states are IDLE and MBUSY, with an 8-bit down-counter cnt.
- accept = instr_valid & ~stall_out & ~flush.
- Per-cycle priority:
  - RESET: state=IDLE, cnt=0, register=bubble, illegal_op=0.
  - flush: state=IDLE, cnt=0, register=bubble, illegal_op=0. Flush wins over stall_in.
  - stall_in: register, state and cnt all hold.
  - IDLE and accept: load the decoded bundle, ctrl_valid = ~illegal, illegal_op = illegal.
    - If the op is a legal M op with latency L>1, go to MBUSY with cnt=L-1.
  - IDLE and not accept: load bubble.
  - MBUSY: register holds; cnt decrements. When cnt==1 the next state is IDLE.

## Timing
- Decode-to-output latency is 1 cycle. Throughput is 1 instruction per cycle outside MBUSY.
- An M op of latency L is presented in EX for exactly L non-stalled cycles.
  - stall_out is high for L-1 of those cycles.
  - mc_last is high on the L-th cycle.
- With L=1, an M op behaves like any other instruction and mc_last is high in its single cycle.
- stall_in cycles freeze everything, including cnt, and stretch the EX presentation.
- flush in MBUSY aborts the op: stall_out falls in the next cycle and the register becomes a bubble.
- RESET mid-MBUSY behaves the same as flush and overrides all other inputs.
- Every output except stall_out and mc_last is a flop output. The reset value of all of them is 0.

## Test plan
- ADD x1,x2,x3 (0x003100B3), valid: next cycle ALU_sel=00000, operand2_sel=0, reg_write_sel=10, reg_write_EN=1, ctrl_valid=1.
- SUB (0x403100B3), then LW (0x0000A083) back-to-back:
  - Cycle 1: ALU_sel=10000.
  - Cycle 2: mem_read=1010, reg_write_sel=01, immeadiate_sel=010.
- DIV (0x023140B3) with DIV_LATENCY=4: ALU_sel=01100 and ctrl_valid=1 held 4 cycles; stall_out high for cycles 1-3; mc_last high only in cycle 4; the following instruction appears in cycle 5.
- DIV with DIV_LATENCY=4 plus flush in cycle 2: next cycle ctrl_valid=0, stall_out=0, the state returns to IDLE, and a new ADD is accepted immediately.
- stall_in held 3 cycles during an ADD: the bundle is unchanged and stall_out=1. Repeat during a DIV: mc_last is delayed by exactly 3 cycles.
- Opcode 0x0000007F: illegal_op=1, ctrl_valid=0, all fields 0.
- MUL (0x023100B3) with ENABLE_M=0: illegal_op=1.
- Assert RESET mid-MBUSY: the cycle after, every output is 0.

Source files
------------

// File: rtl/pipelined_control_unit_if.sv
// ID/EX handshake and control-bundle signals for pipelined_control_unit.
// Signal names follow the decode stage's established port names.
interface pipelined_control_unit_if;
   logic [31:0] Instruction;
   logic        instr_valid;
   logic        stall_in;
   logic        flush;
   logic        stall_out;
   logic        ctrl_valid;
   logic [4:0]  ALU_sel;
   logic        reg_write_EN;
   logic [2:0]  mem_write;
   logic [3:0]  mem_read;
   logic [3:0]  branch_sel;
   logic [2:0]  immeadiate_sel;
   logic        operand1_sel;
   logic        operand2_sel;
   logic [1:0]  reg_write_sel;
   logic        illegal_op;
   logic        mc_last;

   // Fetch / pipeline control side: drives the instruction and stage controls.
   modport master (
      output Instruction, instr_valid, stall_in, flush,
      input  stall_out, ctrl_valid, ALU_sel, reg_write_EN, mem_write, mem_read,
             branch_sel, immeadiate_sel, operand1_sel, operand2_sel,
             reg_write_sel, illegal_op, mc_last
   );

   // Decode stage side.
   modport slave (
      input  Instruction, instr_valid, stall_in, flush,
      output stall_out, ctrl_valid, ALU_sel, reg_write_EN, mem_write, mem_read,
             branch_sel, immeadiate_sel, operand1_sel, operand2_sel,
             reg_write_sel, illegal_op, mc_last
   );
endinterface

// File: rtl/pipelined_control_unit.sv
// RV32IM decode stage: decodes one instruction per cycle into a registered
// ID/EX control bundle, holds M-extension ops in EX for a configurable number
// of cycles while back-pressuring fetch, and flags illegal encodings.
module pipelined_control_unit #(
   parameter bit ENABLE_M    = 1'b1,
   parameter int MUL_LATENCY = 1,
   parameter int DIV_LATENCY = 8
) (
   input logic                      CLK,
   input logic                      RESET,
   pipelined_control_unit_if.slave  bus
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic {IDLE, MBUSY} state_t;

   typedef struct packed {
      logic [4:0] alu_sel;
      logic       reg_write_en;
      logic [2:0] mem_write;
      logic [3:0] mem_read;
      logic [3:0] branch_sel;
      logic [2:0] imm_sel;
      logic       op1_sel;
      logic       op2_sel;
      logic [1:0] reg_write_sel;
   } bundle_t;

   // Instruction fields
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   assign opcode = bus.Instruction[6:0];
   assign funct3 = bus.Instruction[14:12];
   assign funct7 = bus.Instruction[31:25];

   // Register/immediate bits are consumed by later stages, not by decode.
   logic unused_instr_bits;
   assign unused_instr_bits = ^{bus.Instruction[24:15], bus.Instruction[11:7]};

   logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
   logic is_opimm, is_op, is_jump, legal_opc;
   logic f7_muldiv, f7_alt, illegal, is_m_op;
   logic [7:0] m_latency;

   assign is_lui    = (opcode == OPC_LUI);
   assign is_auipc  = (opcode == OPC_AUIPC);
   assign is_jal    = (opcode == OPC_JAL);
   assign is_jalr   = (opcode == OPC_JALR);
   assign is_branch = (opcode == OPC_BRANCH);
   assign is_load   = (opcode == OPC_LOAD);
   assign is_store  = (opcode == OPC_STORE);
   assign is_opimm  = (opcode == OPC_OPIMM);
   assign is_op     = (opcode == OPC_OP);
   assign is_jump   = is_jal | is_jalr;
   assign legal_opc = is_lui | is_auipc | is_jump | is_branch | is_load
                    | is_store | is_opimm | is_op;

   assign f7_muldiv = (funct7 == 7'b0000001);
   assign f7_alt    = (funct7 == 7'b0100000);

   // An M-encoded OP is only legal when the extension is built in.
   assign illegal   = ~legal_opc | (is_op & f7_muldiv & ~ENABLE_M);
   assign is_m_op   = is_op & f7_muldiv & ENABLE_M;

   // funct3[2] separates the divide group from the multiply group.
   assign m_latency = funct3[2] ? 8'(DIV_LATENCY) : 8'(MUL_LATENCY);

   bundle_t bundle_d;

   // Decode the current instruction into the next control bundle.
   always_comb begin
      // NOTE: default every field first so no path leaves a value unassigned
      // (which would infer a latch).
      bundle_d = '0;
      bundle_d.reg_write_en  = ~(is_branch | is_store);
      bundle_d.imm_sel       = is_jal                           ? 3'b001 :
                               (is_jalr | is_load | is_opimm)   ? 3'b010 :
                               is_branch                        ? 3'b011 :
                               is_store                         ? 3'b100 : 3'b000;
      bundle_d.op1_sel       = is_auipc | is_jal | is_branch;
      bundle_d.op2_sel       = ~is_op;
      bundle_d.alu_sel[2:0]  = is_jalr              ? 3'b001 :
                               (is_opimm | is_op)   ? funct3 : 3'b000;
      bundle_d.alu_sel[3]    = is_lui | (is_op & f7_muldiv);
      bundle_d.alu_sel[4]    = is_lui | is_jalr
                             | (is_op & f7_alt & ((funct3 == 3'b000) | (funct3 == 3'b101)))
                             | (is_opimm & f7_alt & (funct3 == 3'b101));
      // Low bits of the memory/branch selects carry raw funct3; the top bit
      // qualifies them.
      bundle_d.branch_sel    = {is_jump | is_branch, is_jump ? 3'b010 : funct3};
      bundle_d.mem_write     = {is_store, funct3[1:0]};
      bundle_d.mem_read      = {is_load, funct3};
      bundle_d.reg_write_sel = is_jump ? 2'b00 : is_load ? 2'b01 : 2'b10;
   end

   state_t  state_q;
   logic [7:0] cnt_q;
   bundle_t bundle_q;
   logic    ctrl_valid_q;
   logic    illegal_q;
   logic    out_is_m_q;
   logic    accept;

   assign bus.stall_out = (state_q == MBUSY) | bus.stall_in;
   assign accept        = bus.instr_valid & ~bus.stall_out & ~bus.flush;

   // Output register and M-op sequencer: reset/flush, then stall, then MBUSY
   // countdown, then normal issue.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (RESET || bus.flush) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bundle_q     <= '0;
         ctrl_valid_q <= 1'b0;
         illegal_q    <= 1'b0;
         out_is_m_q   <= 1'b0;
      end else if (!bus.stall_in) begin
         if (state_q == MBUSY) begin
            cnt_q <= cnt_q - 8'd1;
            if (cnt_q == 8'd1) state_q <= IDLE;
         end else if (accept) begin
            bundle_q     <= illegal ? '0 : bundle_d;
            ctrl_valid_q <= ~illegal;
            illegal_q    <= illegal;
            out_is_m_q   <= is_m_op;
            if (is_m_op && (m_latency > 8'd1)) begin
               state_q <= MBUSY;
               cnt_q   <= m_latency - 8'd1;
            end
         end else begin
            bundle_q     <= '0;
            ctrl_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
            out_is_m_q   <= 1'b0;
         end
      end
   end

   assign bus.ctrl_valid     = ctrl_valid_q;
   assign bus.illegal_op     = illegal_q;
   assign bus.ALU_sel        = bundle_q.alu_sel;
   assign bus.reg_write_EN   = bundle_q.reg_write_en;
   assign bus.mem_write      = bundle_q.mem_write;
   assign bus.mem_read       = bundle_q.mem_read;
   assign bus.branch_sel     = bundle_q.branch_sel;
   assign bus.immeadiate_sel = bundle_q.imm_sel;
   assign bus.operand1_sel   = bundle_q.op1_sel;
   assign bus.operand2_sel   = bundle_q.op2_sel;
   assign bus.reg_write_sel  = bundle_q.reg_write_sel;
   assign bus.mc_last        = ctrl_valid_q & out_is_m_q & (state_q == IDLE);

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench for pipelined_control_unit: three builds (M on with
// MUL=3/DIV=4, M off, M on with MUL=1/DIV=2) see identical stimulus; a
// transaction-level reference model predicts every cycle's outputs.
`timescale 1ns/1ps
module tb_pipelined_control_unit;

   localparam int N = 3;

   localparam logic [31:0] I_ADD = 32'h003100B3;
   localparam logic [31:0] I_SUB = 32'h403100B3;
   localparam logic [31:0] I_LW  = 32'h0000A083;
   localparam logic [31:0] I_DIV = 32'h023140B3;
   localparam logic [31:0] I_MUL = 32'h023100B3;
   localparam logic [31:0] I_ILL = 32'h0000007F;

   logic CLK   = 1'b0;
   logic RESET = 1'b1;
   always #5 CLK = ~CLK;

   pipelined_control_unit_if if_a ();
   pipelined_control_unit_if if_b ();
   pipelined_control_unit_if if_c ();

   pipelined_control_unit #(.ENABLE_M(1'b1), .MUL_LATENCY(3), .DIV_LATENCY(4))
      dut_a (.CLK(CLK), .RESET(RESET), .bus(if_a));
   pipelined_control_unit #(.ENABLE_M(1'b0), .MUL_LATENCY(3), .DIV_LATENCY(4))
      dut_b (.CLK(CLK), .RESET(RESET), .bus(if_b));
   pipelined_control_unit #(.ENABLE_M(1'b1), .MUL_LATENCY(1), .DIV_LATENCY(2))
      dut_c (.CLK(CLK), .RESET(RESET), .bus(if_c));

   typedef struct packed {
      logic [4:0] alu;
      logic       rwe;
      logic [2:0] mw;
      logic [3:0] mr;
      logic [3:0] bs;
      logic [2:0] imm;
      logic       op1;
      logic       op2;
      logic [1:0] rws;
      logic       valid;
      logic       illegal;
      logic       stall_out;
      logic       mc_last;
   } out_t;

   // Build parameters of each instance, as the model sees them.
   bit en_m    [N] = '{1'b1, 1'b0, 1'b1};
   int mul_lat [N] = '{3, 3, 1};
   int div_lat [N] = '{4, 4, 2};

   // Reference model state: what sits in EX and how many more EX cycles it owes.
   out_t cur   [N];
   bit   cur_m [N];
   int   left  [N];

   out_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Instruction semantics from the opcode table.
   function automatic out_t ref_decode(input logic [31:0] ins, input bit m_on,
                                       input int mlat, input int dlat,
                                       output bit is_m, output int lat);
      out_t o;
      logic [2:0] f3;
      logic [6:0] f7;
      bit m_enc;
      o     = '0;
      f3    = ins[14:12];
      f7    = ins[31:25];
      m_enc = (ins[6:0] == 7'b0110011) && (f7 == 7'b0000001);
      o.mw  = {1'b0, f3[1:0]};
      o.mr  = {1'b0, f3};
      o.bs  = {1'b0, f3};
      o.rws = 2'b10;
      o.op2 = 1'b1;
      o.valid = 1'b1;
      case (ins[6:0])
         7'b0110111: begin o.alu = 5'b11000; o.rwe = 1'b1; end                          // LUI
         7'b0010111: begin o.rwe = 1'b1; o.op1 = 1'b1; end                              // AUIPC
         7'b1101111: begin o.rwe = 1'b1; o.imm = 3'b001; o.op1 = 1'b1;
                           o.bs = 4'b1010; o.rws = 2'b00; end                           // JAL
         7'b1100111: begin o.alu = 5'b10001; o.rwe = 1'b1; o.imm = 3'b010;
                           o.bs = 4'b1010; o.rws = 2'b00; end                           // JALR
         7'b1100011: begin o.imm = 3'b011; o.op1 = 1'b1; o.bs[3] = 1'b1; end            // BRANCH
         7'b0000011: begin o.rwe = 1'b1; o.imm = 3'b010; o.mr[3] = 1'b1;
                           o.rws = 2'b01; end                                           // LOAD
         7'b0100011: begin o.imm = 3'b100; o.mw[2] = 1'b1; end                          // STORE
         7'b0010011: begin o.rwe = 1'b1; o.imm = 3'b010;
                           o.alu = {(f3 == 3'b101) && (f7 == 7'b0100000), 1'b0, f3}; end // OP-IMM
         7'b0110011: begin o.rwe = 1'b1; o.op2 = 1'b0;
                           o.alu = {(f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)),
                                    f7 == 7'b0000001, f3}; end                          // OP
         default:    o.valid = 1'b0;
      endcase
      if (m_enc && !m_on) o.valid = 1'b0;
      if (!o.valid) begin
         o = '0;
         o.illegal = 1'b1;
      end
      is_m = o.valid && m_enc;
      lat  = f3[2] ? dlat : mlat;
      return o;
   endfunction

   // Predict this cycle's outputs, then advance the model across the edge.
   task automatic model_step(input int k, input logic [31:0] ins,
                             input bit v, input bit st, input bit fl, input bit rst);
      out_t e;
      out_t d;
      bit   m;
      int   lat;
      e           = cur[k];
      e.stall_out = (left[k] > 0) || st;
      e.mc_last   = cur[k].valid && cur_m[k] && (left[k] == 0);
      exp_q.push_back(e);
      if (rst || fl) begin
         cur[k] = '0; cur_m[k] = 1'b0; left[k] = 0;
      end else if (st) begin
         // frozen
      end else if (left[k] > 0) begin
         left[k] = left[k] - 1;
      end else if (v) begin
         d        = ref_decode(ins, en_m[k], mul_lat[k], div_lat[k], m, lat);
         cur[k]   = d;
         cur_m[k] = m;
         left[k]  = m ? lat - 1 : 0;
      end else begin
         cur[k] = '0; cur_m[k] = 1'b0;
      end
   endtask

   task automatic drive(input logic [31:0] ins, input bit v, input bit st,
                        input bit fl, input bit rst);
      @(negedge CLK);
      RESET = rst;
      if_a.Instruction = ins; if_a.instr_valid = v; if_a.stall_in = st; if_a.flush = fl;
      if_b.Instruction = ins; if_b.instr_valid = v; if_b.stall_in = st; if_b.flush = fl;
      if_c.Instruction = ins; if_c.instr_valid = v; if_c.stall_in = st; if_c.flush = fl;
      for (int k = 0; k < N; k++) model_step(k, ins, v, st, fl, rst);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 9))
         0: w[6:0] = 7'b0110111;
         1: w[6:0] = 7'b0010111;
         2: w[6:0] = 7'b1101111;
         3: w[6:0] = 7'b1100111;
         4: w[6:0] = 7'b1100011;
         5: w[6:0] = 7'b0000011;
         6: w[6:0] = 7'b0100011;
         7: w[6:0] = 7'b0010011;
         8: w[6:0] = 7'b0110011;
         default: ;
      endcase
      if (w[6:0] == 7'b0110011 || w[6:0] == 7'b0010011) begin
         case ($urandom_range(0, 3))
            0: w[31:25] = 7'b0000000;
            1: w[31:25] = 7'b0100000;
            2: w[31:25] = 7'b0000001;
            default: ;
         endcase
      end
      return w;
   endfunction

   function automatic out_t get_actual(input int k);
      out_t a;
      a = '0;
      case (k)
         0: a = '{if_a.ALU_sel, if_a.reg_write_EN, if_a.mem_write, if_a.mem_read,
                  if_a.branch_sel, if_a.immeadiate_sel, if_a.operand1_sel, if_a.operand2_sel,
                  if_a.reg_write_sel, if_a.ctrl_valid, if_a.illegal_op, if_a.stall_out,
                  if_a.mc_last};
         1: a = '{if_b.ALU_sel, if_b.reg_write_EN, if_b.mem_write, if_b.mem_read,
                  if_b.branch_sel, if_b.immeadiate_sel, if_b.operand1_sel, if_b.operand2_sel,
                  if_b.reg_write_sel, if_b.ctrl_valid, if_b.illegal_op, if_b.stall_out,
                  if_b.mc_last};
         default: a = '{if_c.ALU_sel, if_c.reg_write_EN, if_c.mem_write, if_c.mem_read,
                  if_c.branch_sel, if_c.immeadiate_sel, if_c.operand1_sel, if_c.operand2_sel,
                  if_c.reg_write_sel, if_c.ctrl_valid, if_c.illegal_op, if_c.stall_out,
                  if_c.mc_last};
      endcase
      return a;
   endfunction

   task automatic check(input string name, input out_t got, input out_t want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h (alu rwe mw mr bs imm op1 op2 rws valid ill stall mc)",
                  name, got, want);
      end
   endtask

   // Monitor: consumes one expected entry per instance each cycle.
   int mon_cycle = 0;
   initial begin
      forever begin
         @(negedge CLK);
         #2;
         while (exp_q.size() >= N) begin
            for (int k = 0; k < N; k++) begin
               check($sformatf("dut%0d_cycle%0d", k, mon_cycle), get_actual(k), exp_q.pop_front());
            end
            mon_cycle++;
         end
      end
   end

   initial begin
      for (int k = 0; k < N; k++) begin
         cur[k] = '0; cur_m[k] = 1'b0; left[k] = 0;
      end
      if_a.Instruction = '0; if_a.instr_valid = 0; if_a.stall_in = 0; if_a.flush = 0;
      if_b.Instruction = '0; if_b.instr_valid = 0; if_b.stall_in = 0; if_b.flush = 0;
      if_c.Instruction = '0; if_c.instr_valid = 0; if_c.stall_in = 0; if_c.flush = 0;

      // Reset
      drive('0, 0, 0, 0, 1);
      drive('0, 0, 0, 0, 1);
      // ADD, then SUB / LW back-to-back
      drive(I_ADD, 1, 0, 0, 0);
      drive(I_SUB, 1, 0, 0, 0);
      drive(I_LW,  1, 0, 0, 0);
      drive('0, 0, 0, 0, 0);
      // DIV followed by ADD held valid: ADD issues once the DIV completes
      drive(I_DIV, 1, 0, 0, 0);
      repeat (6) drive(I_ADD, 1, 0, 0, 0);
      repeat (2) drive('0, 0, 0, 0, 0);
      // DIV flushed in its second EX cycle, then a new ADD
      drive(I_DIV, 1, 0, 0, 0);
      drive('0, 0, 0, 0, 0);
      drive('0, 0, 0, 1, 0);
      drive(I_ADD, 1, 0, 0, 0);
      drive('0, 0, 0, 0, 0);
      // stall_in for 3 cycles over an ADD, then over a DIV
      drive(I_ADD, 1, 0, 0, 0);
      repeat (3) drive(I_SUB, 1, 1, 0, 0);
      drive('0, 0, 0, 0, 0);
      drive(I_DIV, 1, 0, 0, 0);
      drive('0, 0, 0, 0, 0);
      repeat (3) drive('0, 0, 1, 0, 0);
      repeat (5) drive('0, 0, 0, 0, 0);
      // Illegal opcode, then MUL (illegal on the M-less build)
      drive(I_ILL, 1, 0, 0, 0);
      drive('0, 0, 0, 0, 0);
      drive(I_MUL, 1, 0, 0, 0);
      repeat (4) drive('0, 0, 0, 0, 0);
      // RESET in the middle of a DIV
      drive(I_DIV, 1, 0, 0, 0);
      drive('0, 0, 0, 0, 0);
      drive(I_ADD, 1, 0, 0, 1);
      repeat (2) drive('0, 0, 0, 0, 0);

      // Randomised traffic
      for (int i = 0; i < 2500; i++) begin
         drive(rand_instr(), $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 24) == 0, $urandom_range(0, 99) == 0);
      end
      drive('0, 0, 0, 0, 0);

      repeat (2) @(negedge CLK);
      #4;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d want=0 entries left", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
